// File: rtl/srio_pkg.sv
// Shared SRIO definitions: packet type codes, header field positions,
// doorbell info codes, FSM state encoding and the doorbell response builder.
package srio_pkg;

  // Packet type codes
  localparam logic [3:0] FTYPE_DOORB = 4'hA;
  localparam logic [3:0] FTYPE_NWR   = 4'h5;
  localparam logic [3:0] TTYPE_NWR   = 4'h4;

  // Header field positions (LSB of each field in the 64-bit header beat)
  localparam int TID_LSB   = 56;  // [63:56]
  localparam int FTYPE_LSB = 52;  // [55:52]
  localparam int TTYPE_LSB = 48;  // [51:48]
  localparam int PRIO_LSB  = 45;  // [46:45]
  localparam int SIZE_LSB  = 36;  // [43:36]
  localparam int ADDR_LSB  = 0;   // [33:0]
  localparam int INFO_LSB  = 16;  // [31:16]
  localparam int ADDR_W    = 34;

  // Doorbell info codes
  localparam logic [15:0] DB_INFO_READY      = 16'h0100;
  localparam logic [15:0] DB_INFO_BUSY       = 16'h01FF;
  localparam logic [15:0] DB_INFO_CHECK      = 16'h0101;
  localparam logic [7:0]  DB_INFO_NOTIFY_TAG = 8'h02;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DB_RESP  = 2'd1,
    ST_NWR_DATA = 2'd2,
    ST_DISCARD  = 2'd3
  } tgt_state_e;

  // Doorbell response word; the response priority is one above the request,
  // wrapping inside the 2-bit field.
  function automatic logic [63:0] db_resp_word(input logic [7:0]  tid,
                                               input logic [1:0]  prio,
                                               input logic [15:0] info);
    logic [1:0] resp_prio;
    resp_prio = prio + 2'd1;
    return {tid, FTYPE_DOORB, 4'h0, 1'b0, resp_prio, 1'b0, 12'h000, info, 16'h0000};
  endfunction

endpackage

// File: rtl/db_nwr_target.sv
// SRIO target: answers doorbells, forwards NWRITE payload to a local sink
// and drops every other request type.
module db_nwr_target
  import srio_pkg::*;
#(
  parameter logic [15:0] READY_INFO = DB_INFO_READY,
  parameter logic [15:0] BUSY_INFO  = DB_INFO_BUSY,
  parameter logic [15:0] CHECK_INFO = DB_INFO_CHECK
) (
  input  logic        log_clk,
  input  logic        log_rst,
  input  logic [15:0] src_id,
  // inbound requests
  input  logic        treq_tvalid_in,
  output logic        treq_tready_o,
  input  logic        treq_tlast_in,
  input  logic [63:0] treq_tdata_in,
  input  logic [7:0]  treq_tkeep_in,
  input  logic [31:0] treq_tuser_in,
  // outbound doorbell responses
  output logic        tresp_tvalid_o,
  input  logic        tresp_tready_in,
  output logic        tresp_tlast_o,
  output logic [63:0] tresp_tdata_o,
  output logic [7:0]  tresp_tkeep_o,
  output logic [31:0] tresp_tuser_o,
  // local sink
  input  logic        user_busy_in,
  output logic        user_wr_valid_o,
  output logic [63:0] user_wr_data_o,
  output logic [7:0]  user_wr_keep_o,
  output logic [33:0] user_wr_addr_o,
  output logic        user_wr_last_o,
  // doorbell notification and statistics
  output logic        db_info_valid_o,
  output logic [15:0] db_info_o,
  output logic [15:0] nwr_pkt_cnt_o
);

  tgt_state_e  state_q;
  logic        tresp_tvalid_q, tresp_tlast_q;
  logic [63:0] tresp_tdata_q;
  logic [7:0]  tresp_tkeep_q;
  logic [31:0] tresp_tuser_q;
  logic        user_wr_valid_q, user_wr_last_q;
  logic [63:0] user_wr_data_q;
  logic [7:0]  user_wr_keep_q;
  logic [33:0] user_wr_addr_q;
  logic [33:0] wr_addr_q, wr_addr_d;
  logic        db_info_valid_q;
  logic [15:0] db_info_q;
  logic [15:0] nwr_cnt_q;

  // Header field decode (only meaningful on a header beat)
  logic [7:0]  hdr_tid;
  logic [3:0]  hdr_ftype, hdr_ttype;
  logic [1:0]  hdr_prio;
  logic [33:0] hdr_addr;
  logic [15:0] hdr_info;
  logic [15:0] req_id;
  logic        hdr_acc;
  logic [15:0] resp_info_d;
  logic        notify_d;
  logic        unused_tuser_lo;

  assign hdr_tid   = treq_tdata_in[TID_LSB +: 8];
  assign hdr_ftype = treq_tdata_in[FTYPE_LSB +: 4];
  assign hdr_ttype = treq_tdata_in[TTYPE_LSB +: 4];
  assign hdr_prio  = treq_tdata_in[PRIO_LSB +: 2];
  assign hdr_addr  = treq_tdata_in[ADDR_LSB +: ADDR_W];
  assign hdr_info  = treq_tdata_in[INFO_LSB +: 16];
  assign req_id    = treq_tuser_in[31:16];
  // Low half of tuser carries nothing this target needs
  assign unused_tuser_lo = ^treq_tuser_in[15:0];

  // Ready everywhere except while a doorbell response is pending; forced low in reset
  assign treq_tready_o = !log_rst && (state_q != ST_DB_RESP);
  assign hdr_acc       = (state_q == ST_IDLE) && treq_tvalid_in && treq_tready_o;
  assign wr_addr_d     = wr_addr_q + 34'd8;

  // Doorbell response info and notification selection
  always_comb begin
    resp_info_d = READY_INFO;
    if (hdr_info == CHECK_INFO && user_busy_in) begin
      resp_info_d = BUSY_INFO;
    end
    notify_d = (hdr_info[15:8] == DB_INFO_NOTIFY_TAG);
  end

  // Request FSM with all outputs registered
  always_ff @(posedge log_clk or posedge log_rst) begin
    if (log_rst) begin
      state_q         <= ST_IDLE;
      tresp_tvalid_q  <= 1'b0;
      tresp_tlast_q   <= 1'b0;
      tresp_tdata_q   <= '0;
      tresp_tkeep_q   <= '0;
      tresp_tuser_q   <= '0;
      user_wr_valid_q <= 1'b0;
      user_wr_last_q  <= 1'b0;
      user_wr_data_q  <= '0;
      user_wr_keep_q  <= '0;
      user_wr_addr_q  <= '0;
      wr_addr_q       <= '0;
      db_info_valid_q <= 1'b0;
      db_info_q       <= '0;
      nwr_cnt_q       <= '0;
    end else begin
      user_wr_valid_q <= 1'b0;
      db_info_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (hdr_acc) begin
            if (hdr_ftype == FTYPE_DOORB) begin
              // Doorbells always get a response, even on a single-beat packet
              state_q        <= ST_DB_RESP;
              tresp_tvalid_q <= 1'b1;
              tresp_tlast_q  <= 1'b1;
              tresp_tkeep_q  <= 8'hFF;
              tresp_tdata_q  <= db_resp_word(hdr_tid, hdr_prio, resp_info_d);
              tresp_tuser_q  <= {src_id, req_id};
              if (notify_d) begin
                db_info_valid_q <= 1'b1;
                db_info_q       <= hdr_info;
              end
            end else if (treq_tlast_in) begin
              state_q <= ST_IDLE;
            end else if (hdr_ftype == FTYPE_NWR && hdr_ttype == TTYPE_NWR && !user_busy_in) begin
              state_q   <= ST_NWR_DATA;
              wr_addr_q <= hdr_addr;
            end else begin
              state_q <= ST_DISCARD;
            end
          end
        end
        ST_DB_RESP: begin
          if (tresp_tready_in) begin
            tresp_tvalid_q <= 1'b0;
            tresp_tlast_q  <= 1'b0;
            state_q        <= ST_IDLE;
          end
        end
        ST_NWR_DATA: begin
          if (treq_tvalid_in) begin
            user_wr_valid_q <= 1'b1;
            user_wr_data_q  <= treq_tdata_in;
            user_wr_keep_q  <= treq_tkeep_in;
            user_wr_addr_q  <= wr_addr_q;
            user_wr_last_q  <= treq_tlast_in;
            wr_addr_q       <= wr_addr_d;
            if (treq_tlast_in) begin
              nwr_cnt_q <= nwr_cnt_q + 16'd1;
              state_q   <= ST_IDLE;
            end
          end
        end
        ST_DISCARD: begin
          if (treq_tvalid_in && treq_tlast_in) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign tresp_tvalid_o  = tresp_tvalid_q;
  assign tresp_tlast_o   = tresp_tlast_q;
  assign tresp_tdata_o   = tresp_tdata_q;
  assign tresp_tkeep_o   = tresp_tkeep_q;
  assign tresp_tuser_o   = tresp_tuser_q;
  assign user_wr_valid_o = user_wr_valid_q;
  assign user_wr_data_o  = user_wr_data_q;
  assign user_wr_keep_o  = user_wr_keep_q;
  assign user_wr_addr_o  = user_wr_addr_q;
  assign user_wr_last_o  = user_wr_last_q;
  assign db_info_valid_o = db_info_valid_q;
  assign db_info_o       = db_info_q;
  assign nwr_pkt_cnt_o   = nwr_cnt_q;

endmodule

// File: doc/db_nwr_target.md
DB_NWR_TARGET -- requirements
Module: db_nwr_target

Interface
REQ-001 Parameter READY_INFO, 16'h0100, doorbell info returned when the target is ready.
REQ-002 Parameter BUSY_INFO, 16'h01FF, doorbell info returned when the target is busy.
REQ-003 Parameter CHECK_INFO, 16'h0101, doorbell info that identifies a self-check request.
REQ-004 Port log_clk, in, 1: clock; all logic rising-edge.
REQ-005 Port log_rst, in, 1: reset, asynchronous, active-high.
REQ-006 Port src_id, in, 16: own device ID (system value 16'h00F0).
REQ-007 Ports treq_tvalid_in/in/1, treq_tready_o/out/1, treq_tlast_in/in/1, treq_tdata_in/in/64, treq_tkeep_in/in/8, treq_tuser_in/in/32: inbound request stream; tuser[31:16] is the requester ID.
REQ-008 Ports tresp_tvalid_o/out/1, tresp_tready_in/in/1, tresp_tlast_o/out/1, tresp_tdata_o/out/64, tresp_tkeep_o/out/8, tresp_tuser_o/out/32: outbound doorbell response stream.
REQ-009 Port user_busy_in, in, 1: the local sink cannot accept data.
REQ-010 Ports user_wr_valid_o/out/1, user_wr_data_o/out/64, user_wr_keep_o/out/8, user_wr_addr_o/out/34, user_wr_last_o/out/1: NWR payload to the local sink, with no backpressure.
REQ-011 Ports db_info_valid_o/out/1 (1-cycle pulse) and db_info_o/out/16: data-integrity doorbell notification.
REQ-012 Port nwr_pkt_cnt_o, out, 16: count of completed NWR packets.

Function
REQ-013 Header fields SHALL be decoded as follows: tid [63:56], ftype [55:52], ttype [51:48], prio [46:45], size [43:36], addr [33:0], doorbell info [31:16].
REQ-014 The FSM SHALL have the states IDLE, DB_RESP, NWR_DATA and DISCARD.
REQ-015 treq_tready_o SHALL be 1 in IDLE, NWR_DATA and DISCARD, and 0 in DB_RESP.
REQ-016 IDLE, on an accepted header beat:
- ftype 4'hA: go to DB_RESP.
- ftype 4'h5 with ttype 4'h4: go to NWR_DATA if user_busy_in=0, otherwise go to DISCARD.
- Any other ftype: go to DISCARD.
- In every case, if tlast=1 on the header beat, return to IDLE instead, except for a doorbell.
REQ-017 Doorbell response word SHALL be {tid, 4'hA, 4'h0, 1'b0, prio+1 (2-bit wrap), 1'b0, 12'h0, info, 16'h0}.
- tuser = {src_id, requester ID}.
- tkeep = 8'hFF; tlast = 1.
REQ-018 Doorbell response info selection:
- CHECK_INFO request: BUSY_INFO if user_busy_in=1 on the header cycle, otherwise READY_INFO.
- Request info[15:8]==8'h02: READY_INFO, plus a db_info_valid_o pulse carrying the request info, in the cycle after the header.
- Any other info: READY_INFO.
REQ-019 tresp_tvalid_o SHALL assert in the cycle after the doorbell header is accepted.
- The response holds stable until tresp_tready_in=1.
- The FSM then returns to IDLE in the following cycle.
REQ-020 In NWR_DATA, each accepted beat SHALL drive user_wr_valid_o=1 one cycle later, with the beat's data and keep.
- user_wr_addr_o starts at the header addr and increments by 8 per beat, wrapping at 34 bits.
- user_wr_last_o = treq_tlast_in.
REQ-021 On the NWR last beat, nwr_pkt_cnt_o SHALL increment by 1 (wrap 16'hFFFF -> 0), and the FSM SHALL return to IDLE.
REQ-022 DISCARD SHALL accept and drop beats until tlast, then go to IDLE; nwr_pkt_cnt_o is not incremented.
REQ-023 user_busy_in SHALL be sampled only on the header beat; a change mid-packet has no effect.
REQ-024 Beats with treq_tvalid_in=0 SHALL NOT advance any counter or address.

Reset
REQ-025 While log_rst=1, the FSM SHALL be in IDLE and the following outputs SHALL be 0: tresp_tvalid_o, tresp_tlast_o, tresp_tdata_o, tresp_tkeep_o, tresp_tuser_o, user_wr_*, db_info_valid_o, db_info_o, nwr_pkt_cnt_o.
REQ-026 treq_tready_o SHALL be 0 while log_rst=1.
REQ-027 A reset asserted mid-packet or mid-response SHALL abandon it with no further output beats.

Structure
REQ-028 Shared package srio_pkg SHALL hold FTYPE_DOORB=4'hA, FTYPE_NWR=4'h5, TTYPE_NWR=4'h4, the header bit-field positions, and the doorbell info codes.
REQ-029 No sub-module is required; header decode and FSM SHALL be a single module.

Verification
REQ-030 Doorbell with tid 8'h00, prio 1, info 16'h0101, user_busy_in=0, requester 16'h0001 -> tresp_tdata_o=64'h00A0_4000_0100_0000 (tid 00, ftype A, prio field 2) and tuser=32'h00F0_0001, asserted 1 cycle after acceptance.
REQ-031 Same doorbell with user_busy_in=1 and tresp_tready_in held 0 for 5 cycles -> info 16'h01FF; tvalid and data stable for all 5 cycles; treq_tready_o=0 throughout.
REQ-032 Doorbell with info 16'h0201 -> db_info_valid_o pulses 1 cycle with db_info_o=16'h0201; response info 16'h0100.
REQ-033 NWR at addr 34'h100000 with 4 payload beats -> 4 user_wr beats at addrs 100000/100008/100010/100018; last on beat 4; nwr_pkt_cnt_o goes 0 -> 1.
REQ-034 NWR header with user_busy_in=1, followed by 3 beats -> no user_wr_valid_o, count unchanged, FSM back in IDLE; a following doorbell is answered normally.
REQ-035 log_rst pulsed during beat 2 of an NWR -> outputs go 0 immediately; next NWR starts at its own header address.
